// File: rtl/dt_feeder.sv
// dt_feeder: latches a feature vector on start, streams it one word per cycle
// to a classifier (en/feature), then waits for the classifier result (en_end)
// and presents it on result_class with a one-cycle result_valid pulse.
// Optional build macro DT_FEEDER_TIMEOUT_EN adds a WAIT-state watchdog that
// pulses timeout_err and returns to IDLE after TIMEOUT_CYC cycles without en_end.
module dt_feeder #(
  parameter int FEATURE_WIDE = 13,
  parameter int FEATURE_NUM  = 16,
  parameter int CLASS_W      = 5,
  parameter int TIMEOUT_CYC  = 64
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [FEATURE_NUM*FEATURE_WIDE-1:0] feat_vec,
  output logic                              busy,
  output logic                              en,
  output logic [FEATURE_WIDE-1:0]           feature,
  input  logic [CLASS_W-1:0]                out_class,
  input  logic                              en_end,
  output logic [CLASS_W-1:0]                result_class,
  output logic                              result_valid,
  output logic                              timeout_err
);

  localparam int VEC_W = FEATURE_NUM * FEATURE_WIDE;
  localparam int IDX_W = (FEATURE_NUM > 1) ? $clog2(FEATURE_NUM) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FEATURE_NUM - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t                    state_r, state_s;
  logic [IDX_W-1:0]          idx_r, idx_s;
  logic [VEC_W-1:0]          shadow_r, shadow_s;
  logic                      en_r, en_s;
  logic [FEATURE_WIDE-1:0]   feature_r, feature_s;
  logic                      busy_r, busy_s;
  logic [CLASS_W-1:0]        result_class_r, result_class_s;
  logic                      result_valid_r, result_valid_s;

`ifdef DT_FEEDER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC);
  logic [CNT_W-1:0]          wait_cnt_r, wait_cnt_s;
  logic                      timeout_err_r, timeout_err_s;
`endif

  // Select feature word i out of a packed feature vector.
  function automatic logic [FEATURE_WIDE-1:0] word_at(input logic [VEC_W-1:0] vec, input int i);
    word_at = vec[i*FEATURE_WIDE +: FEATURE_WIDE];
  endfunction

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_s        = state_r;
    idx_s          = idx_r;
    shadow_s       = shadow_r;
    en_s           = 1'b0;
    feature_s      = {FEATURE_WIDE{1'b0}};
    result_class_s = result_class_r;
    result_valid_s = 1'b0;
`ifdef DT_FEEDER_TIMEOUT_EN
    wait_cnt_s     = wait_cnt_r;
    timeout_err_s  = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        // en_end in IDLE is deliberately ignored, even alongside start.
        if (start) begin
          shadow_s  = feat_vec;
          idx_s     = {IDX_W{1'b0}};
          en_s      = 1'b1;
          feature_s = word_at(feat_vec, 0);
          state_s   = ST_STREAM;
        end else begin
          state_s   = ST_IDLE;
        end
      end
      ST_STREAM: begin
        // en_r low inside STREAM marks the single drain cycle after the last word.
        if (en_r) begin
          if (idx_r == IDX_LAST) begin
            en_s      = 1'b0;
            feature_s = {FEATURE_WIDE{1'b0}};
          end else begin
            idx_s     = idx_r + 1'b1;
            en_s      = 1'b1;
            feature_s = word_at(shadow_r, int'(idx_r) + 1);
          end
        end else begin
          state_s = ST_WAIT;
`ifdef DT_FEEDER_TIMEOUT_EN
          wait_cnt_s = {CNT_W{1'b0}};
`endif
        end
      end
      ST_WAIT: begin
        // A result arriving on the expiry cycle takes priority over the watchdog.
        if (en_end) begin
          result_class_s = out_class;
          result_valid_s = 1'b1;
          state_s        = ST_DONE;
        end else begin
`ifdef DT_FEEDER_TIMEOUT_EN
          wait_cnt_s = wait_cnt_r + 1'b1;
          if (wait_cnt_s == CNT_LIMIT) begin
            timeout_err_s = 1'b1;
            wait_cnt_s    = {CNT_W{1'b0}};
            state_s       = ST_IDLE;
          end else begin
            state_s       = ST_WAIT;
          end
`else
          state_s = ST_WAIT;
`endif
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // State, counters, shadow copy and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      idx_r          <= {IDX_W{1'b0}};
      shadow_r       <= {VEC_W{1'b0}};
      en_r           <= 1'b0;
      feature_r      <= {FEATURE_WIDE{1'b0}};
      busy_r         <= 1'b0;
      result_class_r <= {CLASS_W{1'b0}};
      result_valid_r <= 1'b0;
    end else begin
      state_r        <= state_s;
      idx_r          <= idx_s;
      shadow_r       <= shadow_s;
      en_r           <= en_s;
      feature_r      <= feature_s;
      busy_r         <= busy_s;
      result_class_r <= result_class_s;
      result_valid_r <= result_valid_s;
    end
  end

`ifdef DT_FEEDER_TIMEOUT_EN
  // Watchdog counter and its expiry pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_r    <= {CNT_W{1'b0}};
      timeout_err_r <= 1'b0;
    end else begin
      wait_cnt_r    <= wait_cnt_s;
      timeout_err_r <= timeout_err_s;
    end
  end

  assign timeout_err = timeout_err_r;
`else
  assign timeout_err = 1'b0;
`endif

  assign busy         = busy_r;
  assign en           = en_r;
  assign feature      = feature_r;
  assign result_class = result_class_r;
  assign result_valid = result_valid_r;

endmodule

// File: tb/tb_dt_feeder.sv
// Self-checking bench for dt_feeder: table of transactions, hand-written
// reset/abort sequences, and randomized transactions. Expected behaviour per
// cycle is computed from the transaction timeline (start at cycle 0, words on
// cycles 1..N, drain on N+1, WAIT from N+2, result N+3+d, idle N+4+d).
module tb_dt_feeder;
  localparam int FW = 13;
  localparam int FN = 16;
  localparam int CW = 5;
  localparam int TO = 64;
  localparam int VW = FW * FN;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [VW-1:0] feat_vec;
  logic          busy;
  logic          en;
  logic [FW-1:0] feature;
  logic [CW-1:0] out_class;
  logic          en_end;
  logic [CW-1:0] result_class;
  logic          result_valid;
  logic          timeout_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [CW-1:0] exp_rc;

  typedef struct {
    logic [VW-1:0] vec;
    int            d;          // WAIT cycles before en_end; -1 = never (watchdog)
    logic [CW-1:0] cls;
    int            restart_at; // cycle of an extra (ignored) start, -1 = none
    int            end_at;     // cycle of a stray en_end in IDLE/STREAM, -1 = none
    logic [CW-1:0] end_cls;
  } txn_t;

  dt_feeder #(.FEATURE_WIDE(FW), .FEATURE_NUM(FN), .CLASS_W(CW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .feat_vec(feat_vec), .busy(busy),
    .en(en), .feature(feature), .out_class(out_class), .en_end(en_end),
    .result_class(result_class), .result_valid(result_valid), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog sim time exhausted");
    $fatal(1, "tb_dt_feeder time limit");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < FN; i++) v[i*FW +: FW] = FW'($urandom);
    return v;
  endfunction

  function automatic txn_t mk(input logic [VW-1:0] vec, input int d, input logic [CW-1:0] cls,
                              input int r, input int e, input logic [CW-1:0] ec);
    txn_t t;
    t.vec = vec; t.d = d; t.cls = cls; t.restart_at = r; t.end_at = e; t.end_cls = ec;
    return t;
  endfunction

  // Run one transaction, checking every output on every cycle.
  task automatic do_txn(input txn_t t);
    int last;
    logic e_en, e_busy, e_rv, e_to;
    logic [FW-1:0] e_feat;
    last = (t.d >= 0) ? FN + 4 + t.d : FN + TO + 3;
    for (int c = 0; c <= last; c++) begin
      @(posedge clk); #1;
      cyc = c;
      start     = (c == 0) || (c == t.restart_at);
      feat_vec  = (c == 0) ? t.vec : rand_vec();
      en_end    = 1'b0;
      out_class = CW'($urandom);
      if (t.d >= 0 && c == FN + 2 + t.d) begin
        en_end = 1'b1; out_class = t.cls;
      end else if (c == t.end_at) begin
        en_end = 1'b1; out_class = t.end_cls;
      end
      @(negedge clk);
      e_en = 1'b0; e_feat = '0; e_busy = 1'b1; e_rv = 1'b0; e_to = 1'b0;
      if (c == 0) begin
        e_busy = 1'b0;
      end else if (c <= FN) begin
        e_en = 1'b1; e_feat = t.vec[(c-1)*FW +: FW];
      end else if (t.d >= 0) begin
        if (c == FN + 3 + t.d) begin
          e_rv = 1'b1; exp_rc = t.cls;
        end else if (c == FN + 4 + t.d) begin
          e_busy = 1'b0;
        end
      end else begin
        if (c == FN + TO + 2) begin
          e_to = 1'b1; e_busy = 1'b0;
        end else if (c == FN + TO + 3) begin
          e_busy = 1'b0;
        end
      end
      chk("en", 32'(en), 32'(e_en));
      chk("feature", 32'(feature), 32'(e_feat));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("result_valid", 32'(result_valid), 32'(e_rv));
      chk("result_class", 32'(result_class), 32'(exp_rc));
      chk("timeout_err", 32'(timeout_err), 32'(e_to));
    end
    start = 1'b0; en_end = 1'b0;
  endtask

  // Start a stream, then assert reset in cycle k and check the immediate abort.
  task automatic abort_at(input logic [VW-1:0] vec, input int k);
    for (int c = 0; c <= k; c++) begin
      @(posedge clk); #1;
      cyc = c;
      start = (c == 0); feat_vec = vec; en_end = 1'b0;
    end
    @(negedge clk);
    chk("abort_busy_before", 32'(busy), 32'd1);
    if (k <= FN) chk("abort_feature_before", 32'(feature), 32'(vec[(k-1)*FW +: FW]));
    #1 rst_n = 1'b0;
    #1;
    chk("abort_en", 32'(en), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_feature", 32'(feature), 32'd0);
    chk("abort_result_valid", 32'(result_valid), 32'd0);
    chk("abort_result_class", 32'(result_class), 32'd0);
    chk("abort_timeout_err", 32'(timeout_err), 32'd0);
    exp_rc = '0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  initial begin
    txn_t tbl[6];
    logic [VW-1:0] spec_vec, ones_vec;
    int spec_words[FN] = '{3590, 3270, 37, 370, 207, 70, 60, 700, 700, 27, 67, 67, 67, 67, 67, 7};
    txn_t r;
    int d;

    for (int i = 0; i < FN; i++) spec_vec[i*FW +: FW] = FW'(spec_words[i]);
    ones_vec = '1;
    tbl[0] = mk(spec_vec,   3,  5'd9,  -1,     -1,     5'd0);
    tbl[1] = mk(rand_vec(), 0,  5'd21, 6,      -1,     5'd0);
    tbl[2] = mk(rand_vec(), 2,  5'd17, -1,     4,      5'd3);
    tbl[3] = mk(ones_vec,   63, 5'd31, 80,     0,      5'd3);
    tbl[4] = mk('0,         1,  5'd0,  FN + 4, FN + 1, 5'd3);
    tbl[5] = mk(spec_vec,   5,  5'd12, 1,      FN,     5'd3);

    rst_n = 1'b0; start = 1'b0; feat_vec = '0; en_end = 1'b0; out_class = '0;
    exp_rc = '0;
    #3;
    chk("reset_en", 32'(en), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_feature", 32'(feature), 32'd0);
    chk("reset_result_valid", 32'(result_valid), 32'd0);
    chk("reset_result_class", 32'(result_class), 32'd0);
    chk("reset_timeout_err", 32'(timeout_err), 32'd0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

    for (int i = 0; i < 6; i++) do_txn(tbl[i]);

    abort_at(spec_vec, 9);
    do_txn(mk(spec_vec, 0, 5'd7, -1, -1, 5'd0));
    abort_at(rand_vec(), FN + 5);
    do_txn(mk(rand_vec(), 4, 5'd22, 3, -1, 5'd0));

`ifdef DT_FEEDER_TIMEOUT_EN
    do_txn(mk(rand_vec(), -1, 5'd0, 40, 2, 5'd3));
    do_txn(mk(rand_vec(), 0, 5'd14, -1, -1, 5'd0));
`endif

    for (int n = 0; n < 10; n++) begin
      d = $urandom_range(0, 30);
      r = mk(rand_vec(), d, CW'($urandom), -1, -1, CW'($urandom));
      if ($urandom_range(0, 1) == 1) r.restart_at = $urandom_range(1, FN + 3 + d);
      if ($urandom_range(0, 1) == 1) r.end_at = $urandom_range(0, FN + 1);
      do_txn(r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dt_feeder.md
DT_FEEDER -- requirements
Module: dt_feeder

Interface
REQ-001 FEATURE_WIDE, 13, integer bit width of one feature word.
REQ-002 FEATURE_NUM, 16, feature words per classification (2..16).
REQ-003 CLASS_W, 5, classifier result width.
REQ-004 TIMEOUT_CYC, 64, maximum WAIT cycles for en_end (only used with DT_FEEDER_TIMEOUT_EN).
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle request to classify feat_vec.
REQ-008 feat_vec  in  FEATURE_NUM*FEATURE_WIDE  feature vector; word i at bits [i*FEATURE_WIDE +: FEATURE_WIDE].
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 en  out  1  feature-valid strobe to the classifier.
REQ-011 feature  out  FEATURE_WIDE  serial feature word to the classifier.
REQ-012 out_class  in  CLASS_W  classifier result.
REQ-013 en_end  in  1  classifier result-valid.
REQ-014 result_class  out  CLASS_W  captured result, held until next capture.
REQ-015 result_valid  out  1  one-cycle pulse when result_class updates.
REQ-016 timeout_err  out  1  one-cycle pulse on watchdog expiry.

Function
REQ-017 FSM states IDLE, STREAM, WAIT, DONE; all outputs registered.
REQ-018 IDLE: start=1 latches feat_vec into an internal shadow register, clears index counter, goes to STREAM.
REQ-019 STREAM: en=1 and feature=shadow word[idx] for idx=0..FEATURE_NUM-1, one word per cycle, word 0 first, no gaps.
REQ-020 First en=1 cycle is the cycle after start is sampled (latency 1).
REQ-021 After word FEATURE_NUM-1, en=0 and feature=0 next cycle; FSM goes to WAIT.
REQ-022 WAIT: en_end=1 captures out_class into result_class, goes to DONE.
REQ-023 DONE: result_valid=1 for exactly one cycle, then IDLE; busy falls with it.
REQ-024 en_end in IDLE or STREAM is ignored; no capture, no state change.
REQ-025 start while busy=1 is ignored; shadow register and stream unaffected.
REQ-026 feat_vec changes after the start cycle do not affect the stream.
REQ-027 start and en_end in the same IDLE cycle: start is honoured, en_end ignored.
REQ-028 Index counter width ceil(log2(FEATURE_NUM)); no wrap beyond FEATURE_NUM-1.
REQ-029 Minimum start-to-result_valid latency: FEATURE_NUM+3 cycles with en_end arriving first WAIT cycle.

Reset
REQ-030 rst_n=0 forces IDLE immediately: en=0, feature=0, busy=0, result_class=0, result_valid=0, timeout_err=0, counters and shadow register 0.
REQ-031 Reset mid-STREAM or mid-WAIT aborts without result_valid; first post-reset start begins a clean stream at word 0.

Configuration
REQ-032 Macro DT_FEEDER_TIMEOUT_EN defined: WAIT counter increments each cycle; if it reaches TIMEOUT_CYC without en_end, timeout_err pulses one cycle, result_class unchanged, FSM returns to IDLE.
REQ-033 en_end on the same cycle the counter reaches TIMEOUT_CYC wins: capture, no timeout_err.
REQ-034 Macro undefined: no watchdog logic; WAIT persists until en_end; timeout_err tied 0.

Verification
REQ-035 Reset release, start with words 3590,3270,37,370,207,70,60,700,700,27,67,67,67,67,67,7 (word 0 first) -> en high 16 consecutive cycles, feature shows those values in order.
REQ-036 en_end=1 with out_class=5'd9 three cycles into WAIT -> result_class=9, result_valid one-cycle pulse, busy low next cycle.
REQ-037 Second start pulse during STREAM word 5 -> ignored; exactly 16 en cycles, single result_valid.
REQ-038 rst_n=0 during word 8 -> en=0, busy=0 immediately; new start streams from word 0, no stale result_valid.
REQ-039 With DT_FEEDER_TIMEOUT_EN, TIMEOUT_CYC=64, en_end never asserted -> timeout_err pulse 64 cycles into WAIT, result_class unchanged, IDLE.
REQ-040 en_end pulsed during STREAM with out_class=5'd3 -> no capture; result_class keeps prior value.
